// File: rtl/survivor_out.sv
// Viterbi output stage: picks the minimum-metric state each step and, at window end, queues that state's survivor as a decoded byte.
// Latency: best_state, refresh_out and byte_valid appear 1 cycle after the capturing edge; a captured byte always spends >=1 cycle in the FIFO.
// Backpressure: valid/ready pop on byte_ready; a capture into a full FIFO without a pop is dropped and sets sticky overflow. Optional: SURVIVOR_OUT_RENORM_EN.
module survivor_out #(
  parameter int PM_W       = 4,
  parameter int PATH_W     = 8,
  parameter int PTR_W      = 3,
`ifdef SURVIVOR_OUT_RENORM_EN
  parameter int FIFO_DEPTH = 2,
  parameter int RENORM_TH  = 12
`else
  parameter int FIFO_DEPTH = 2
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  input  logic [PM_W-1:0]   path_metric_00,
  input  logic [PM_W-1:0]   path_metric_01,
  input  logic [PM_W-1:0]   path_metric_10,
  input  logic [PM_W-1:0]   path_metric_11,
  input  logic [PATH_W-1:0] survivor_00,
  input  logic [PATH_W-1:0] survivor_01,
  input  logic [PATH_W-1:0] survivor_10,
  input  logic [PATH_W-1:0] survivor_11,
  input  logic [PTR_W-1:0]  write_pointer_in,
  input  logic              byte_ready,
  output logic [PATH_W-1:0] decoded_byte,
  output logic              byte_valid,
  output logic [1:0]        best_state,
  output logic              refresh_out,
  output logic              overflow,
  output logic [7:0]        byte_count,
  output logic              renorm_req
);

  // FIFO addressing; depth is a power of two so pointers wrap for free.
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0]      DEPTH_C  = (AW+1)'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = '1;

  // Best-state selection signals
  logic [PM_W-1:0]   min_lo;
  logic [PM_W-1:0]   min_hi;
  logic              sel_lo;
  logic              sel_hi;
  logic [1:0]        best_idx;
  logic [PATH_W-1:0] best_surv;

  // Control
  logic capture;
  logic full;
  logic pop;
  logic push;

  // Registered state
  logic [PATH_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       cnt_q, cnt_d;
  logic [1:0]        best_state_q, best_state_d;
  logic              refresh_q;
  logic              overflow_q, overflow_d;
  logic [7:0]        byte_count_q, byte_count_d;

  // Pairwise minimum tree; strict '<' keeps the lower index on ties at every level.
  always_comb begin
    sel_lo = (path_metric_01 < path_metric_00);
    min_lo = sel_lo ? path_metric_01 : path_metric_00;
    sel_hi = (path_metric_11 < path_metric_10);
    min_hi = sel_hi ? path_metric_11 : path_metric_10;
    if (min_hi < min_lo) begin
      best_idx = {1'b1, sel_hi};
    end else begin
      best_idx = {1'b0, sel_lo};
    end
  end

  // Survivor of the winning state, the candidate decoded byte.
  always_comb begin
    best_surv = survivor_00;
    unique case (best_idx)
      2'b00:   best_surv = survivor_00;
      2'b01:   best_surv = survivor_01;
      2'b10:   best_surv = survivor_10;
      default: best_surv = survivor_11;
    endcase
  end

  // Window end, FIFO handshake and next-state computation.
  always_comb begin
    capture      = valid_in && (write_pointer_in == LAST_PTR);
    full         = (cnt_q == DEPTH_C);
    pop          = (cnt_q != '0) && byte_ready;
    // A full FIFO still accepts a capture when the head leaves on the same edge.
    push         = capture && (!full || pop);

    wr_ptr_d     = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d     = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    cnt_d        = cnt_q;
    if (push && !pop) begin
      cnt_d = cnt_q + 1'b1;
    end else if (pop && !push) begin
      cnt_d = cnt_q - 1'b1;
    end

    best_state_d = valid_in ? best_idx : best_state_q;
    overflow_d   = overflow_q || (capture && !push);
    byte_count_d = pop ? byte_count_q + 8'd1 : byte_count_q;
  end

  // FIFO storage; only the slot at the write pointer is written.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push) begin
      mem_q[wr_ptr_q] <= best_surv;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Status registers: best state, refresh pulse, sticky overflow, pop counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      best_state_q <= 2'b00;
      refresh_q    <= 1'b0;
      overflow_q   <= 1'b0;
      byte_count_q <= 8'd0;
    end else begin
      best_state_q <= best_state_d;
      // Pulses for dropped captures too: upstream must restart its window either way.
      refresh_q    <= capture;
      overflow_q   <= overflow_d;
      byte_count_q <= byte_count_d;
    end
  end

`ifdef SURVIVOR_OUT_RENORM_EN
  logic [PM_W-1:0] min_pm;
  logic            renorm_q;

  // Overall minimum metric, only needed for the renormalisation request.
  always_comb begin
    min_pm = (min_hi < min_lo) ? min_hi : min_lo;
  end

  // Request renormalisation while even the best metric sits at/above threshold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      renorm_q <= 1'b0;
    end else if (valid_in) begin
      renorm_q <= (min_pm >= PM_W'(RENORM_TH));
    end
  end

  assign renorm_req = renorm_q;
`else
  assign renorm_req = 1'b0;
`endif

  // Head of FIFO reads zero when empty so downstream never sees stale data.
  assign byte_valid   = (cnt_q != '0);
  assign decoded_byte = byte_valid ? mem_q[rd_ptr_q] : '0;
  assign best_state   = best_state_q;
  assign refresh_out  = refresh_q;
  assign overflow     = overflow_q;
  assign byte_count   = byte_count_q;

endmodule

// File: tb/tb_survivor_out.sv
// Randomized + directed bench for survivor_out with a queue scoreboard.
// A driver updates a behavioural model per step; a negedge monitor compares all outputs.
// Define SURVIVOR_OUT_RENORM_EN for both files to exercise renorm_req.
module tb_survivor_out;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       valid_in = 1'b0;
  logic [3:0] pm00 = '0, pm01 = '0, pm10 = '0, pm11 = '0;
  logic [7:0] sv00 = '0, sv01 = '0, sv10 = '0, sv11 = '0;
  logic [2:0] wptr = '0;
  logic       byte_ready = 1'b0;

  logic [7:0] decoded_byte;
  logic       byte_valid;
  logic [1:0] best_state;
  logic       refresh_out;
  logic       overflow;
  logic [7:0] byte_count;
  logic       renorm_req;

  always #5 clk = ~clk;

  survivor_out dut (
    .clk             (clk),
    .rst             (rst_n),
    .valid_in        (valid_in),
    .path_metric_00  (pm00),
    .path_metric_01  (pm01),
    .path_metric_10  (pm10),
    .path_metric_11  (pm11),
    .survivor_00     (sv00),
    .survivor_01     (sv01),
    .survivor_10     (sv10),
    .survivor_11     (sv11),
    .write_pointer_in(wptr),
    .byte_ready      (byte_ready),
    .decoded_byte    (decoded_byte),
    .byte_valid      (byte_valid),
    .best_state      (best_state),
    .refresh_out     (refresh_out),
    .overflow        (overflow),
    .byte_count      (byte_count),
    .renorm_req      (renorm_req)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Scoreboard of bytes the model says are sitting in the FIFO, oldest first.
  logic [7:0] sb[$];

  // Expected observable state after the most recent edge.
  int         model_occ   = 0;
  logic [1:0] exp_best    = 2'd0;
  logic       exp_refresh = 1'b0;
  logic       exp_ovf     = 1'b0;
  logic [7:0] exp_cnt     = 8'd0;
  logic       exp_renorm  = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Lowest index among the minimum metrics.
  function automatic int ref_best(input int m[4]);
    int b = 0;
    for (int i = 1; i < 4; i++) if (m[i] < m[b]) b = i;
    return b;
  endfunction

  // Drive one cycle of inputs, let the edge happen, then advance the model.
  task automatic step(input bit v, input int ptr, input int m0, input int m1, input int m2,
                      input int m3, input logic [7:0] s0, input logic [7:0] s1,
                      input logic [7:0] s2, input logic [7:0] s3, input bit rdy);
    int         m[4];
    logic [7:0] s[4];
    int         b;
    bit         pop, cap;
    m = '{m0, m1, m2, m3};
    s = '{s0, s1, s2, s3};
    b = ref_best(m);
    valid_in = v; wptr = 3'(ptr); byte_ready = rdy;
    pm00 = 4'(m0); pm01 = 4'(m1); pm10 = 4'(m2); pm11 = 4'(m3);
    sv00 = s0; sv01 = s1; sv10 = s2; sv11 = s3;
    pop = (model_occ > 0) && rdy;
    cap = v && (ptr == 7);
    @(posedge clk);
    #1;
    if (v) exp_best = 2'(b);
    exp_refresh = cap;
    if (cap) begin
      if (model_occ < 2 || pop) begin
        sb.push_back(s[b]);
        model_occ++;
      end else begin
        exp_ovf = 1'b1;
      end
    end
    if (pop) begin
      model_occ--;
      exp_cnt++;
    end
`ifdef SURVIVOR_OUT_RENORM_EN
    if (v) exp_renorm = (m[b] >= 12);
`endif
  endtask

  task automatic idle(input bit rdy);
    step(1'b0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, rdy);
  endtask

  task automatic clear_model();
    sb.delete();
    model_occ = 0; exp_best = 2'd0; exp_refresh = 1'b0;
    exp_ovf = 1'b0; exp_cnt = 8'd0; exp_renorm = 1'b0;
  endtask

  // Monitor: mid-cycle, compare every output with the model; pop the scoreboard on a handshake.
  always @(negedge clk) begin
    chk("byte_valid", int'(byte_valid), int'(model_occ > 0));
    if (byte_valid) begin
      if (sb.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL sb_underflow: DUT byte 0x%0h but no byte expected", decoded_byte);
      end else begin
        chk("decoded_byte", int'(decoded_byte), int'(sb[0]));
        if (byte_ready) void'(sb.pop_front());
      end
    end else begin
      chk("decoded_byte_empty", int'(decoded_byte), 0);
    end
    chk("best_state", int'(best_state), int'(exp_best));
    chk("refresh_out", int'(refresh_out), int'(exp_refresh));
    chk("overflow", int'(overflow), int'(exp_ovf));
    chk("byte_count", int'(byte_count), int'(exp_cnt));
    chk("renorm_req", int'(renorm_req), int'(exp_renorm));
  end

  initial begin
    // Reset
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_byte_valid", int'(byte_valid), 0);
    chk("rst_best_state", int'(best_state), 0);
    chk("rst_byte_count", int'(byte_count), 0);

    // Metrics 3,1,4,2 -> state 01 wins, byte 0xC0, ready high
    step(1'b1, 7, 3, 1, 4, 2, 8'hA0, 8'hC0, 8'hE0, 8'h00, 1'b1);
    chk("tp1_best", int'(best_state), 1);
    chk("tp1_byte", int'(decoded_byte), 8'hC0);
    chk("tp1_refresh", int'(refresh_out), 1);
    idle(1'b1);
    chk("tp1_refresh_gone", int'(refresh_out), 0);
    chk("tp1_count", int'(byte_count), 1);

    // All metrics tied -> state 00
    step(1'b1, 7, 5, 5, 5, 5, 8'hFF, 8'h00, 8'hAA, 8'h55, 1'b0);
    chk("tie_best", int'(best_state), 0);
    chk("tie_byte", int'(decoded_byte), 8'hFF);
    idle(1'b1);
    idle(1'b1);

    // Three captures with ready low -> third dropped, overflow
    step(1'b1, 7, 0, 1, 2, 3, 8'h11, 8'h00, 8'h00, 8'h00, 1'b0);
    step(1'b1, 7, 0, 1, 2, 3, 8'h22, 8'h00, 8'h00, 8'h00, 1'b0);
    step(1'b1, 7, 0, 1, 2, 3, 8'h33, 8'h00, 8'h00, 8'h00, 1'b0);
    chk("ovf_set", int'(overflow), 1);
    chk("ovf_head", int'(decoded_byte), 8'h11);
    // Full: pop and capture 0x44 on the same edge
    step(1'b1, 7, 0, 1, 2, 3, 8'h44, 8'h00, 8'h00, 8'h00, 1'b1);
    chk("popcap_head", int'(decoded_byte), 8'h22);
    idle(1'b1);
    chk("popcap_next", int'(decoded_byte), 8'h44);
    idle(1'b1);
    idle(1'b1);

    // Pointer sweep 0..6 and valid_in=0 at pointer 7: no capture
    for (int p = 0; p < 7; p++)
      step(1'b1, p, $urandom_range(15), $urandom_range(15), $urandom_range(15),
           $urandom_range(15), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'b1);
    step(1'b0, 7, 1, 2, 3, 4, 8'h5A, 8'h5A, 8'h5A, 8'h5A, 1'b1);
    chk("sweep_no_byte", int'(byte_valid), 0);

`ifdef SURVIVOR_OUT_RENORM_EN
    step(1'b1, 2, 13, 14, 15, 13, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
    chk("renorm_hi", int'(renorm_req), 1);
    step(1'b1, 3, 9, 4, 15, 13, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
    chk("renorm_lo", int'(renorm_req), 0);
`endif

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      int p;
      p = ($urandom_range(2) == 0) ? 7 : $urandom_range(7);
      step($urandom_range(3) != 0, p, $urandom_range(15), $urandom_range(15),
           $urandom_range(15), $urandom_range(15), 8'($urandom), 8'($urandom),
           8'($urandom), 8'($urandom), $urandom_range(1) == 1);
    end

    // Reset mid-cycle with a byte pending: outputs clear before the next edge
    step(1'b1, 7, 2, 1, 0, 3, 8'h01, 8'h02, 8'h03, 8'h04, 1'b0);
    #2;
    rst_n = 1'b0;
    clear_model();
    #1;
    chk("arst_byte_valid", int'(byte_valid), 0);
    chk("arst_decoded", int'(decoded_byte), 0);
    chk("arst_best", int'(best_state), 0);
    chk("arst_count", int'(byte_count), 0);
    chk("arst_ovf", int'(overflow), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    // Fresh window needed after reset
    step(1'b1, 3, 1, 0, 2, 3, 8'h77, 8'h66, 8'h55, 8'h44, 1'b1);
    chk("post_rst_nocap", int'(byte_valid), 0);
    step(1'b1, 7, 1, 0, 2, 3, 8'h77, 8'h66, 8'h55, 8'h44, 1'b1);
    chk("post_rst_cap", int'(decoded_byte), 8'h66);

    // Drain
    repeat (4) idle(1'b1);
    chk("sb_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Safety net against a stuck run.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/survivor_out.md
Name: survivor_out

Overview:
- Output stage of the Viterbi decoder; sits directly downstream of the compare-select stage.
- Each valid step: takes the four new path metrics and the four updated 8-bit survivor paths, and picks the best (minimum-metric) state.
- When the 8-bit window completes, captures that state's survivor as a decoded byte into a small output FIFO.
- Pulses refresh back upstream to start the next window.

Parameters:
- PM_W, 4, path metric width
- PATH_W, 8, survivor/window length in bits
- PTR_W, 3, write pointer width (window length = 2^PTR_W = PATH_W)
- FIFO_DEPTH, 2, output FIFO entries (power of two)
- RENORM_TH, 12, metric threshold for renormalisation request (used only with RENORM_EN)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- valid_in  in  1  metrics/paths/pointer valid this cycle
- path_metric_00  in  PM_W  new metric, state 00
- path_metric_01  in  PM_W  new metric, state 01
- path_metric_10  in  PM_W  new metric, state 10
- path_metric_11  in  PM_W  new metric, state 11
- survivor_00  in  PATH_W  updated survivor, state 00
- survivor_01  in  PATH_W  updated survivor, state 01
- survivor_10  in  PATH_W  updated survivor, state 10
- survivor_11  in  PATH_W  updated survivor, state 11
- write_pointer_in  in  PTR_W  bit position just written into survivors
- byte_ready  in  1  downstream accepts decoded byte
- decoded_byte  out  PATH_W  FIFO head; bit 7 = oldest decision
- byte_valid  out  1  FIFO non-empty
- best_state  out  2  registered index of minimum-metric state
- refresh_out  out  1  one-cycle pulse to compare-select stage
- overflow  out  1  sticky; a window was dropped because FIFO was full
- byte_count  out  8  decoded bytes accepted by downstream, wraps 255->0
- renorm_req  out  1  see Optional Feature

Behaviour:
- Reset (rst low, asynchronous): FIFO empty, byte_valid=0, decoded_byte=0, best_state=0, refresh_out=0, overflow=0, byte_count=0, renorm_req=0.
- Best-state selection (combinational): minimum of the four metrics, compared unsigned at PM_W bits. Ties go to the lowest index: 00 < 01 < 10 < 11.
- best_state register: updates on every clk edge with valid_in=1; holds otherwise.
- Window capture:
  - Occurs on an edge with valid_in=1 and write_pointer_in == 2^PTR_W-1.
  - Captures the winning survivor (selected in the same cycle) into the FIFO.
  - byte_valid rises the cycle after the capture edge (latency 1) if the FIFO was empty.
- refresh_out:
  - Registered; high for exactly one cycle following every capture edge, including a dropped capture.
  - Low at all other times; never asserted for valid_in=0 or pointer != 7.
- Output handshake:
  - Pop on an edge with byte_valid && byte_ready.
  - decoded_byte and byte_valid must stay stable while byte_valid && !byte_ready.
  - decoded_byte reads 0 when empty.
  - byte_count increments on each pop.
- FIFO boundaries:
  - Capture while full with no pop: capture dropped, FIFO contents unchanged, overflow set and held until reset.
  - Capture while full with simultaneous pop: both proceed, no overflow.
  - Pop while empty: ignored.
  - Capture while empty with byte_ready high: the byte still sits one cycle in the FIFO (no bypass).
- write_pointer_in values other than 7: no capture, regardless of survivor content.
- Reset asserted mid-window or with FIFO non-empty: all state cleared immediately; pending bytes lost. After reset release, the first capture needs a fresh pointer==7 step.

Optional Feature:
- Macro: SURVIVOR_OUT_RENORM_EN.
- Defined: renorm_req is registered.
  - High in the cycle after any valid_in step whose minimum metric >= RENORM_TH.
  - Cleared after any valid step with minimum < RENORM_TH.
  - Cleared on reset.
- Undefined: renorm_req tied 0; no comparator logic present.

Test Plan:
- Metrics 3,1,4,2 (00..11), pointer 7, valid, survivors 0xA0,0xC0,0xE0,0x00, byte_ready=1 -> next cycle best_state=01, decoded_byte=0xC0, byte_valid=1, refresh_out=1 for one cycle; byte_count=1 after following edge.
- Metrics all 5, pointer 7, survivors 0xFF,0x00,0xAA,0x55 -> tie resolves to state 00, decoded_byte=0xFF.
- byte_ready=0, three consecutive pointer-7 captures of 0x11,0x22,0x33 -> FIFO holds 0x11,0x22; overflow=1; refresh_out pulses three times; then byte_ready=1 pops 0x11, then 0x22; byte_count=2.
- FIFO full, pop and capture 0x44 on same edge -> no overflow; subsequent outputs 0x22, then 0x44.
- Pointer sweep 0..6 with valid_in=1 -> no byte_valid, no refresh_out, best_state tracks per step; valid_in=0 with pointer 7 -> no capture.
- FIFO holding 1 byte, rst pulled low mid-cycle -> outputs zero immediately, before next clk edge; with SURVIVOR_OUT_RENORM_EN, min metric 13 -> renorm_req=1 next cycle, min 4 -> renorm_req=0.
